// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - round-robin shared prescaled down-counter timer
//
// Purpose:
//   One prescaled down-counter timer shared by NUM_REQ requesters. A round-robin
//   arbiter hands the timer to one requester at a time. The owner gets a one-cycle
//   done pulse when its requested number of ticks (PRESCALE clk cycles each) expires.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   req        in   [NUM_REQ]        per-requester request level
//   req_ticks  in   [NUM_REQ*CNT_W]  delay of requester i at [i*CNT_W +: CNT_W]
//   grant      out  [NUM_REQ]        one-hot owner of the timer (registered)
//   done       out  [NUM_REQ]        one-hot one-cycle expiry pulse (registered)
//   busy       out  high while not idle
//   tick       out  one-cycle pulse per prescaler wrap while running
module timer_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int PRESCALE = 16,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_ticks,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     tick
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [IDX_W-1:0]   pick, owner_next;
  logic [CNT_W-1:0]   cnt, cnt_n, pick_ticks;
  logic [PRE_W-1:0]   pre, pre_n;
  logic [NUM_REQ-1:0] grant_n, done_n, pick_onehot;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // Scan downward so the candidate closest to rr_ptr is assigned last and wins.
  always_comb begin
    pick = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(rr_ptr) + k)]) pick = wrap_idx(int'(rr_ptr) + k);
    end
  end

  always_comb begin
    pick_ticks = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) pick_ticks = req_ticks[i*CNT_W +: CNT_W];
    end
  end

  assign pick_onehot = NUM_REQ'(1) << pick;
  assign owner_next  = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
  assign tick        = (state == RUN) && (pre == PRE_LAST);
  assign busy        = (state != IDLE);

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    cnt_n    = cnt;
    pre_n    = pre;
    grant_n  = grant;
    done_n   = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_n = pick;
          cnt_n   = pick_ticks;
          pre_n   = '0;
          if (pick_ticks != '0) begin
            grant_n = pick_onehot;
            state_n = RUN;
          end else begin
            // Zero-tick job skips RUN entirely and never raises grant.
            done_n  = pick_onehot;
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (!req[owner]) begin
          // Abort takes priority over a coincident final tick: no done pulse.
          grant_n  = '0;
          rr_ptr_n = owner_next;
          state_n  = IDLE;
        end else if (tick) begin
          pre_n = '0;
          if (cnt <= CNT_W'(1)) begin
            grant_n = '0;
            done_n  = grant;
            state_n = DONE;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end else begin
          pre_n = pre + PRE_W'(1);
        end
      end
      DONE: begin
        rr_ptr_n = owner_next;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
      pre    <= '0;
      grant  <= '0;
      done   <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      owner  <= owner_n;
      cnt    <= cnt_n;
      pre    <= pre_n;
      grant  <= grant_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - directed self-checking bench for timer_scheduler
//
// Purpose:
//   Two instances: dut_a (NUM_REQ=4, PRESCALE=4, CNT_W=8) for reset, single job,
//   round-robin, zero delay and abort; dut_b (PRESCALE=1) for the per-cycle tick case.
//   Cycle 0 is the cycle in which a request is first driven; cycle k is sampled
//   2 time units after the k-th following rising edge.
module tb_timer_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, grant_a, done_a;
  logic [31:0] ticks_a;
  logic        busy_a, tick_a;
  logic [3:0]  req_b, grant_b, done_b;
  logic [31:0] ticks_b;
  logic        busy_b, tick_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  timer_scheduler #(.NUM_REQ(4), .PRESCALE(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_ticks(ticks_a),
    .grant(grant_a), .done(done_a), .busy(busy_a), .tick(tick_a)
  );

  timer_scheduler #(.NUM_REQ(4), .PRESCALE(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_ticks(ticks_b),
    .grant(grant_b), .done(done_b), .busy(busy_b), .tick(tick_b)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic bad;
    rst = 1'b0; req_a = '0; ticks_a = '0; req_b = '0; ticks_b = '0;
    step(); step();
    checks++; if (grant_a !== 4'b0000) $display("FAIL reset_grant got %b want 0000", grant_a); else passes++;
    checks++; if (done_a !== 4'b0000) $display("FAIL reset_done got %b want 0000", done_a); else passes++;
    checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else passes++;
    checks++; if (tick_a !== 1'b0) $display("FAIL reset_tick got %b want 0", tick_a); else passes++;
    rst = 1'b1;
    step();
    // start a job on requester 1, then reset in the middle of RUN
    req_a = 4'b0010; ticks_a[15:8] = 8'd5;
    step(); step(); step();
    checks++; if (grant_a !== 4'b0010) $display("FAIL midrun_grant got %b want 0010", grant_a); else passes++;
    checks++; if (busy_a !== 1'b1) $display("FAIL midrun_busy got %b want 1", busy_a); else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if ({grant_a, done_a, busy_a, tick_a} !== 10'b0)
      $display("FAIL async_reset got grant=%b done=%b busy=%b tick=%b want all 0", grant_a, done_a, busy_a, tick_a);
    else passes++;
    req_a = '0;
    step();
    rst = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (busy_a !== 1'b0 || grant_a !== 4'b0 || done_a !== 4'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL idle_after_reset got activity=%b want 0", bad); else passes++;
  endtask

  task automatic test_single_job();
    logic [3:0] exp_g, exp_d;
    logic       exp_t;
    req_a = 4'b0100; ticks_a = '0; ticks_a[23:16] = 8'd3;
    for (int c = 1; c <= 15; c++) begin
      step();
      exp_g = (c >= 1 && c <= 12) ? 4'b0100 : 4'b0000;
      exp_t = (c == 4 || c == 8 || c == 12);
      exp_d = (c == 13) ? 4'b0100 : 4'b0000;
      checks++; if (grant_a !== exp_g) $display("FAIL single_grant c=%0d got %b want %b", c, grant_a, exp_g); else passes++;
      checks++; if (tick_a !== exp_t) $display("FAIL single_tick c=%0d got %b want %b", c, tick_a, exp_t); else passes++;
      checks++; if (done_a !== exp_d) $display("FAIL single_done c=%0d got %b want %b", c, done_a, exp_d); else passes++;
      if (c == 13) req_a = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    logic       overlap;
    apply_reset();
    req_a = 4'b1111; ticks_a = {8'd1, 8'd1, 8'd1, 8'd1};
    overlap = 1'b0;
    for (int c = 1; c <= 29; c++) begin
      step();
      if ((grant_a & done_a) != 4'b0 || (grant_a != 4'b0 && done_a != 4'b0)) overlap = 1'b1;
      if ((c - 1) % 6 == 0) begin
        exp = 4'b0001 << (((c - 1) / 6) % 4);
        checks++; if (grant_a !== exp) $display("FAIL rr_grant c=%0d got %b want %b", c, grant_a, exp); else passes++;
      end
      if (c >= 5 && (c - 5) % 6 == 0) begin
        exp = 4'b0001 << (((c - 5) / 6) % 4);
        checks++; if (done_a !== exp) $display("FAIL rr_done c=%0d got %b want %b", c, done_a, exp); else passes++;
      end
    end
    req_a = 4'b0000;
    step();
    checks++; if (overlap !== 1'b0) $display("FAIL rr_grant_done_overlap got %b want 0", overlap); else passes++;
    checks++; if (busy_a !== 1'b0) $display("FAIL rr_idle_busy got %b want 0", busy_a); else passes++;
  endtask

  task automatic test_zero_delay();
    req_a = 4'b1000; ticks_a = '0;
    checks++; if (busy_a !== 1'b0) $display("FAIL zero_busy_c0 got %b want 0", busy_a); else passes++;
    step();
    checks++; if (done_a !== 4'b1000) $display("FAIL zero_done_c1 got %b want 1000", done_a); else passes++;
    checks++; if (grant_a !== 4'b0000) $display("FAIL zero_grant_c1 got %b want 0000", grant_a); else passes++;
    checks++; if (busy_a !== 1'b1) $display("FAIL zero_busy_c1 got %b want 1", busy_a); else passes++;
    req_a = 4'b0000;
    step();
    checks++; if (busy_a !== 1'b0) $display("FAIL zero_busy_c2 got %b want 0", busy_a); else passes++;
    checks++; if (done_a !== 4'b0000) $display("FAIL zero_done_c2 got %b want 0000", done_a); else passes++;
    checks++; if (grant_a !== 4'b0000) $display("FAIL zero_grant_c2 got %b want 0000", grant_a); else passes++;
  endtask

  task automatic test_abort();
    logic early_done;
    req_a = 4'b0011; ticks_a = '0; ticks_a[7:0] = 8'd10; ticks_a[15:8] = 8'd2;
    early_done = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c <= 7) begin
        checks++; if (grant_a !== 4'b0001) $display("FAIL abort_grant0 c=%0d got %b want 0001", c, grant_a); else passes++;
      end
      if (c == 7) req_a = 4'b0010;
      if (c == 8) begin
        checks++; if (grant_a !== 4'b0000) $display("FAIL abort_grant_c8 got %b want 0000", grant_a); else passes++;
        checks++; if (busy_a !== 1'b0) $display("FAIL abort_busy_c8 got %b want 0", busy_a); else passes++;
      end
      if (c == 9) begin
        checks++; if (grant_a !== 4'b0010) $display("FAIL abort_next_grant_c9 got %b want 0010", grant_a); else passes++;
      end
      if (c != 17 && done_a !== 4'b0000) early_done = 1'b1;
      if (c == 17) begin
        checks++; if (done_a !== 4'b0010) $display("FAIL abort_next_done_c17 got %b want 0010", done_a); else passes++;
        req_a = 4'b0000;
      end
    end
    checks++; if (early_done !== 1'b0) $display("FAIL abort_spurious_done got %b want 0", early_done); else passes++;
  endtask

  task automatic test_prescale_one();
    logic bad_t, bad_g, bad_d;
    req_b = 4'b0010; ticks_b = '0; ticks_b[15:8] = 8'd255;
    bad_t = 1'b0; bad_g = 1'b0; bad_d = 1'b0;
    for (int c = 1; c <= 258; c++) begin
      step();
      if (tick_b !== (c <= 255)) bad_t = 1'b1;
      if (grant_b !== ((c <= 255) ? 4'b0010 : 4'b0000)) bad_g = 1'b1;
      if (c == 256) begin
        checks++; if (done_b !== 4'b0010) $display("FAIL p1_done_c256 got %b want 0010", done_b); else passes++;
        req_b = 4'b0000;
      end else if (done_b !== 4'b0000) begin
        bad_d = 1'b1;
      end
    end
    checks++; if (bad_t !== 1'b0) $display("FAIL p1_tick_pattern got bad=%b want 0", bad_t); else passes++;
    checks++; if (bad_g !== 1'b0) $display("FAIL p1_grant_pattern got bad=%b want 0", bad_g); else passes++;
    checks++; if (bad_d !== 1'b0) $display("FAIL p1_done_pattern got bad=%b want 0", bad_d); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_zero_delay();
    test_abort();
    test_prescale_one();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
